fb_wr_arbiter: RTL and testbench
================================

Name: fb_wr_arbiter

Overview:
Shares the single-port 12-bit pixel frame buffer between the VGA display read path and the game-logic pixel writer. Display reads have absolute priority and pass through combinationally, so VGA driver timing is unchanged. Writer requests are buffered in a small FIFO and drained into the RAM only when the display is not reading (h/v blanking). Sits between the VGA driver, the game/sprite engine, and the frame-buffer RAM.

Parameters:
DEPTH, 16, write FIFO entries (power of 2, ≥2); 160-cycle hblank drains a full FIFO every line
AW, 4, log2(DEPTH)

Ports:
vga_clk  in  1  25 MHz pixel clock; all logic on rising edge
clr  in  1  synchronous reset, active-high
vga_rdn  in  1  display read request from VGA driver, active-low
vga_row  in  9  display row address
vga_col  in  10  display column address
wr_valid  in  1  writer has a pixel to store
wr_ready  out  1  FIFO can accept; transfer when wr_valid & wr_ready
wr_row  in  9  writer pixel row
wr_col  in  10  writer pixel column
wr_data  in  12  bbbb_gggg_rrrr pixel
ram_addr  out  19  frame-buffer address {row[8:0], col[9:0]} (1024-pixel row stride)
ram_we  out  1  frame-buffer write enable, active-high
ram_din  out  12  frame-buffer write data
fifo_level  out  AW+1  entries currently queued (0..DEPTH)
err_oob  out  1  sticky: an out-of-range write was discarded
idle  out  1  FIFO empty

Behaviour:
- Reset (clr high at a clock edge): FIFO pointers and level cleared, err_oob=0. While clr is high, ram_we=0 and wr_ready=0. After reset: wr_ready=1, fifo_level=0, idle=1.
- Display path, combinational: vga_rdn=0 -> ram_addr={vga_row,vga_col}, ram_we=0. No cycle of latency is added.
- Write path: vga_rdn=1 and FIFO non-empty -> ram_addr/ram_din come from the FIFO head, ram_we=1, and the head is popped at that clock edge. This gives one write per cycle through blanking. If vga_rdn=1 and the FIFO is empty, ram_we=0 and ram_addr={vga_row,vga_col}.
- Head data comes from registered FIFO storage. ram_we is gated combinationally: vga_rdn & ~empty & ~clr.
- wr_ready = ~full & ~clr. It does not depend on pop in the same cycle; no push occurs when full.
- Push latency: an entry pushed at edge N is first eligible for RAM write in the cycle after edge N. An empty FIFO never writes in the push cycle.
- Simultaneous push and pop: level is unchanged and ordering is preserved (strict FIFO, in write order).
- Out-of-range request: wr_row ≥ 480 or wr_col ≥ 640 with wr_valid & wr_ready:
  - handshake completes
  - entry is not queued
  - err_oob set at that edge; it stays set until clr
- A display read never stalls. Writes may stall indefinitely during active video.
- fifo_level: registered, AW+1 bits. Pointers are AW bits and wrap modulo DEPTH. full = level==DEPTH, empty = level==0.
- idle = empty.
- Reset mid-drain: queued entries are discarded with no further writes. The RAM write in the reset cycle is suppressed.

Decomposition:
- Shared package fb_pkg:
  - H_ACTIVE=640, V_ACTIVE=480
  - ROW_W=9, COL_W=10, PIX_W=12, FB_ADDR_W=19
  - typedef fb_wr_t {row, col, data}, 31 bits; the FIFO stores this packed word
- One sub-module, fb_wr_fifo: synchronous FIFO, DEPTH×31. Ports: push, pop, din, dout (head), full, empty, level, clr.
- Arbitration, range check and sticky error live in the top module.

Test Plan:
- Reset: clr=1 for 2 cycles with wr_valid=1, vga_rdn=1 -> ram_we=0, wr_ready=0. After release: wr_ready=1, fifo_level=0, idle=1, err_oob=0.
- Blanking write: vga_rdn=1, push row=5, col=7, data=12'hABC -> next cycle ram_we=1, ram_addr=5127, ram_din=12'hABC. Following cycle fifo_level=0, ram_we=0.
- Active-video stall:
  - vga_rdn=0, sweep vga_col 0..; push 16 entries -> ram_we=0 throughout and ram_addr tracks {vga_row,vga_col} every cycle
  - fifo_level=16, wr_ready=0, and the 17th request is not accepted
  - raise vga_rdn -> 16 consecutive writes in push order, then idle=1
- Display preemption mid-drain: 8 queued, vga_rdn=1 for 3 cycles then 0 -> exactly 3 writes, level=5, ram_addr switches to the display address in the same cycle vga_rdn falls.
- Out of range: push row=480 col=0, then row=0 col=640 -> both handshakes complete, level stays 0, no ram_we, err_oob=1 and stays 1 until clr.
- Simultaneous push/pop at level 1 with vga_rdn=1 -> level remains 1, writes emerge in order. Reset asserted at level 8 -> next cycle level=0 and no write occurs in the reset cycle.

Source files
------------

// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the frame-buffer write arbitration slice.
//   H_ACTIVE / V_ACTIVE : visible display area in pixels / lines
//   ROW_W / COL_W       : widths of the row and column address fields
//   PIX_W               : width of a bbbb_gggg_rrrr pixel
//   FB_ADDR_W           : width of the frame-buffer address {row, col}
//   fb_wr_t             : one queued pixel write, {row, col, data}, 31 bits
//   fb_addr()           : builds the RAM address with a 1024-pixel row stride
// ---------------------------------------------------------------------------
package fb_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;

    localparam int ROW_W     = 9;
    localparam int COL_W     = 10;
    localparam int PIX_W     = 12;
    localparam int FB_ADDR_W = ROW_W + COL_W;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [PIX_W-1:0] data;
    } fb_wr_t;

    // The column field is a full 10 bits, so concatenation gives a
    // 1024-pixel row stride even though only 640 columns are visible.
    function automatic logic [FB_ADDR_W-1:0] fb_addr(
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col
    );
        return {row, col};
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// ---------------------------------------------------------------------------
// fb_wr_fifo
// Synchronous DEPTH-entry FIFO holding pending frame-buffer writes.
//   clk   : clock, rising edge
//   clr   : synchronous active-high reset, clears pointers and level
//   push  : store din at the tail this edge (ignored while full)
//   din   : entry to store
//   pop   : drop the head entry this edge (ignored while empty)
//   dout  : current head entry, read from registered storage
//   full  : level == DEPTH
//   empty : level == 0
//   level : number of queued entries, 0..DEPTH
// ---------------------------------------------------------------------------
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push,
    input  fb_wr_t        din,
    input  logic          pop,
    output fb_wr_t        dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    fb_wr_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Entry storage. It needs no reset: the level counter decides what is
    // valid, and stale contents are never presented as a write.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    // A push and a pop in the same cycle move both pointers and leave the
    // level unchanged.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fb_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fb_wr_arbiter
// Shares the single-port frame-buffer RAM between the VGA display read path
// and the game-logic pixel writer. Display reads win outright and pass
// straight through; writer requests are queued and drained while the display
// is not reading.
//   vga_clk    : 25 MHz pixel clock, rising edge
//   clr        : synchronous active-high reset
//   vga_rdn    : display read request, active-low
//   vga_row    : display row address
//   vga_col    : display column address
//   wr_valid   : writer has a pixel to store
//   wr_ready   : queue can accept; transfer on wr_valid & wr_ready
//   wr_row     : writer pixel row
//   wr_col     : writer pixel column
//   wr_data    : writer pixel, bbbb_gggg_rrrr
//   ram_addr   : frame-buffer address {row, col}
//   ram_we     : frame-buffer write enable, active-high
//   ram_din    : frame-buffer write data
//   fifo_level : entries currently queued
//   err_oob    : sticky flag, an off-screen write was dropped
//   idle       : queue empty
// ---------------------------------------------------------------------------
module fb_wr_arbiter
    import fb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                 vga_clk,
    input  logic                 clr,
    input  logic                 vga_rdn,
    input  logic [ROW_W-1:0]     vga_row,
    input  logic [COL_W-1:0]     vga_col,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ROW_W-1:0]     wr_row,
    input  logic [COL_W-1:0]     wr_col,
    input  logic [PIX_W-1:0]     wr_data,
    output logic [FB_ADDR_W-1:0] ram_addr,
    output logic                 ram_we,
    output logic [PIX_W-1:0]     ram_din,
    output logic [AW:0]          fifo_level,
    output logic                 err_oob,
    output logic                 idle
);

    fb_wr_t wr_entry;
    fb_wr_t head;
    logic   full;
    logic   empty;
    logic   accept;
    logic   in_range;
    logic   push;

    assign wr_entry = '{row: wr_row, col: wr_col, data: wr_data};

    // Off-screen pixels still complete their handshake so the writer never
    // stalls on them; they are simply not queued.
    assign in_range = (wr_row < ROW_W'(V_ACTIVE)) && (wr_col < COL_W'(H_ACTIVE));
    assign accept   = wr_valid & wr_ready;
    assign push     = accept & in_range;

    // Ready looks only at full, not at a same-cycle pop, so there is no
    // combinational path from vga_rdn to the writer handshake.
    assign wr_ready = ~full & ~clr;

    // Drain only while the display is idle. Gating with clr kills the write
    // in a reset cycle even though the queue still looks non-empty.
    assign ram_we   = vga_rdn & ~empty & ~clr;
    assign ram_addr = ram_we ? fb_addr(head.row, head.col)
                             : fb_addr(vga_row, vga_col);
    assign ram_din  = head.data;
    assign idle     = empty;

    fb_wr_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (vga_clk),
        .clr   (clr),
        .push  (push),
        .din   (wr_entry),
        .pop   (ram_we),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // Sticky error: set when an off-screen pixel is accepted and dropped,
    // held until the next reset.
    always_ff @(posedge vga_clk) begin
        if (clr) begin
            err_oob <= 1'b0;
        end else if (accept & ~in_range) begin
            err_oob <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fb_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_wr_arbiter
// Directed bench for fb_wr_arbiter: reset, blanking write, active-video
// stall and full drain, display preemption, off-screen drops, simultaneous
// push/pop and reset while entries are queued.
// ---------------------------------------------------------------------------
module tb_fb_wr_arbiter;

    logic        vga_clk;
    logic        clr;
    logic        vga_rdn;
    logic [8:0]  vga_row;
    logic [9:0]  vga_col;
    logic        wr_valid;
    logic        wr_ready;
    logic [8:0]  wr_row;
    logic [9:0]  wr_col;
    logic [11:0] wr_data;
    logic [18:0] ram_addr;
    logic        ram_we;
    logic [11:0] ram_din;
    logic [4:0]  fifo_level;
    logic        err_oob;
    logic        idle;

    int n_checks;
    int n_pass;

    fb_wr_arbiter #(
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .vga_clk    (vga_clk),
        .clr        (clr),
        .vga_rdn    (vga_rdn),
        .vga_row    (vga_row),
        .vga_col    (vga_col),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_din    (ram_din),
        .fifo_level (fifo_level),
        .err_oob    (err_oob),
        .idle       (idle)
    );

    // 25 MHz pixel clock, scaled to a 10-unit period.
    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    // Drive every input, then let combinational outputs settle.
    task automatic applyStimulus(
        input logic        rdn,
        input int          vrow,
        input int          vcol,
        input logic        wv,
        input int          wrow,
        input int          wcol,
        input int          wdata
    );
        vga_rdn  = rdn;
        vga_row  = 9'(vrow);
        vga_col  = 10'(vcol);
        wr_valid = wv;
        wr_row   = 9'(wrow);
        wr_col   = 10'(wcol);
        wr_data  = 12'(wdata);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(
        input string       tag,
        input logic [31:0] observed,
        input logic [31:0] expected
    );
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    // Advance past the next rising edge and away from it.
    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    // Address with a 1024-pixel row stride.
    function automatic int pix_addr(input int row, input int col);
        return row * 1024 + col;
    endfunction

    // Directed sequence.
    initial begin
        n_checks = 0;
        n_pass   = 0;

        // Reset for two cycles with a writer and an idle display present.
        clr = 1'b1;
        applyStimulus(1'b1, 0, 0, 1'b1, 1, 1, 12'h111);
        checkOutput("rst_we_c0", 32'(ram_we), 32'd0);
        checkOutput("rst_ready_c0", 32'(wr_ready), 32'd0);
        tick();
        checkOutput("rst_we_c1", 32'(ram_we), 32'd0);
        checkOutput("rst_ready_c1", 32'(wr_ready), 32'd0);
        tick();
        clr = 1'b0;
        applyStimulus(1'b1, 0, 0, 1'b0, 0, 0, 0);
        checkOutput("post_rst_ready", 32'(wr_ready), 32'd1);
        checkOutput("post_rst_level", 32'(fifo_level), 32'd0);
        checkOutput("post_rst_idle", 32'(idle), 32'd1);
        checkOutput("post_rst_oob", 32'(err_oob), 32'd0);
        checkOutput("post_rst_we", 32'(ram_we), 32'd0);

        // Single write during blanking; never written in its own push cycle.
        applyStimulus(1'b1, 0, 0, 1'b1, 5, 7, 12'hABC);
        checkOutput("blank_push_we", 32'(ram_we), 32'd0);
        checkOutput("blank_push_ready", 32'(wr_ready), 32'd1);
        tick();
        applyStimulus(1'b1, 0, 0, 1'b0, 0, 0, 0);
        checkOutput("blank_we", 32'(ram_we), 32'd1);
        checkOutput("blank_addr", 32'(ram_addr), 32'd5127);
        checkOutput("blank_din", 32'(ram_din), 32'hABC);
        checkOutput("blank_level", 32'(fifo_level), 32'd1);
        tick();
        checkOutput("blank_after_level", 32'(fifo_level), 32'd0);
        checkOutput("blank_after_we", 32'(ram_we), 32'd0);
        checkOutput("blank_after_idle", 32'(idle), 32'd1);

        // Active video: fill the queue while the display sweeps columns.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 20, i, 1'b1, i, 100 + i, 12'h100 + i);
            checkOutput("stall_we", 32'(ram_we), 32'd0);
            checkOutput("stall_addr", 32'(ram_addr), 32'(pix_addr(20, i)));
            checkOutput("stall_ready", 32'(wr_ready), 32'd1);
            tick();
        end
        applyStimulus(1'b0, 20, 16, 1'b1, 100, 100, 12'hFFF);
        checkOutput("full_level", 32'(fifo_level), 32'd16);
        checkOutput("full_ready", 32'(wr_ready), 32'd0);
        checkOutput("full_we", 32'(ram_we), 32'd0);
        checkOutput("full_addr", 32'(ram_addr), 32'(pix_addr(20, 16)));
        tick();
        checkOutput("full_17th_level", 32'(fifo_level), 32'd16);

        // Blanking: all 16 entries leave in push order, one per cycle.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 0, 0, 1'b0, 0, 0, 0);
            checkOutput("drain_we", 32'(ram_we), 32'd1);
            checkOutput("drain_addr", 32'(ram_addr), 32'(pix_addr(k, 100 + k)));
            checkOutput("drain_din", 32'(ram_din), 32'h100 + 32'(k));
            tick();
        end
        checkOutput("drain_idle", 32'(idle), 32'd1);
        checkOutput("drain_level", 32'(fifo_level), 32'd0);
        checkOutput("drain_we_end", 32'(ram_we), 32'd0);

        // Queue 8 entries during active video.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 30, i, 1'b1, 200 + i, 300 + i, 12'h800 + i);
            tick();
        end
        checkOutput("pre_level", 32'(fifo_level), 32'd8);

        // Three blanking cycles, then the display takes the RAM back.
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b1, 0, 0, 1'b0, 0, 0, 0);
            checkOutput("pre_we", 32'(ram_we), 32'd1);
            checkOutput("pre_addr", 32'(ram_addr), 32'(pix_addr(200 + j, 300 + j)));
            tick();
        end
        applyStimulus(1'b0, 33, 44, 1'b0, 0, 0, 0);
        checkOutput("pre_switch_we", 32'(ram_we), 32'd0);
        checkOutput("pre_switch_addr", 32'(ram_addr), 32'(pix_addr(33, 44)));
        checkOutput("pre_switch_level", 32'(fifo_level), 32'd5);
        tick();
        checkOutput("pre_hold_level", 32'(fifo_level), 32'd5);

        // Remaining five continue in order at the next blanking.
        for (int j = 3; j < 8; j++) begin
            applyStimulus(1'b1, 0, 0, 1'b0, 0, 0, 0);
            checkOutput("rest_addr", 32'(ram_addr), 32'(pix_addr(200 + j, 300 + j)));
            checkOutput("rest_din", 32'(ram_din), 32'h800 + 32'(j));
            tick();
        end
        checkOutput("rest_idle", 32'(idle), 32'd1);

        // Off-screen row, then off-screen column: accepted and dropped.
        applyStimulus(1'b1, 0, 0, 1'b1, 480, 0, 12'h321);
        checkOutput("oob_row_ready", 32'(wr_ready), 32'd1);
        checkOutput("oob_row_flag0", 32'(err_oob), 32'd0);
        tick();
        applyStimulus(1'b1, 0, 0, 1'b1, 0, 640, 12'h654);
        checkOutput("oob_row_flag", 32'(err_oob), 32'd1);
        checkOutput("oob_row_level", 32'(fifo_level), 32'd0);
        checkOutput("oob_row_we", 32'(ram_we), 32'd0);
        checkOutput("oob_col_ready", 32'(wr_ready), 32'd1);
        tick();
        applyStimulus(1'b1, 0, 0, 1'b0, 0, 0, 0);
        checkOutput("oob_col_flag", 32'(err_oob), 32'd1);
        checkOutput("oob_col_level", 32'(fifo_level), 32'd0);
        checkOutput("oob_col_we", 32'(ram_we), 32'd0);

        // Last visible pixel is in range.
        applyStimulus(1'b1, 0, 0, 1'b1, 479, 639, 12'h5A5);
        tick();
        // Push B while A is written: level holds at 1.
        applyStimulus(1'b1, 0, 0, 1'b1, 1, 2, 12'h111);
        checkOutput("edge_we", 32'(ram_we), 32'd1);
        checkOutput("edge_addr", 32'(ram_addr), 32'd491135);
        checkOutput("edge_din", 32'(ram_din), 32'h5A5);
        checkOutput("edge_level", 32'(fifo_level), 32'd1);
        tick();
        applyStimulus(1'b1, 0, 0, 1'b1, 3, 4, 12'h222);
        checkOutput("pp1_level", 32'(fifo_level), 32'd1);
        checkOutput("pp1_addr", 32'(ram_addr), 32'd1026);
        checkOutput("pp1_din", 32'(ram_din), 32'h111);
        tick();
        applyStimulus(1'b1, 0, 0, 1'b0, 0, 0, 0);
        checkOutput("pp2_level", 32'(fifo_level), 32'd1);
        checkOutput("pp2_addr", 32'(ram_addr), 32'd3076);
        checkOutput("pp2_din", 32'(ram_din), 32'h222);
        tick();
        checkOutput("pp_end_level", 32'(fifo_level), 32'd0);
        checkOutput("pp_end_we", 32'(ram_we), 32'd0);
        checkOutput("oob_sticky", 32'(err_oob), 32'd1);

        // Reset with 8 entries queued: nothing written, queue discarded.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 40, i, 1'b1, 50 + i, 60 + i, 12'h700 + i);
            tick();
        end
        checkOutput("rq_level", 32'(fifo_level), 32'd8);
        clr = 1'b1;
        applyStimulus(1'b1, 0, 0, 1'b0, 0, 0, 0);
        checkOutput("rq_clr_we", 32'(ram_we), 32'd0);
        checkOutput("rq_clr_ready", 32'(wr_ready), 32'd0);
        tick();
        clr = 1'b0;
        applyStimulus(1'b1, 0, 0, 1'b0, 0, 0, 0);
        checkOutput("rq_after_level", 32'(fifo_level), 32'd0);
        checkOutput("rq_after_we", 32'(ram_we), 32'd0);
        checkOutput("rq_after_idle", 32'(idle), 32'd1);
        checkOutput("rq_after_oob", 32'(err_oob), 32'd0);
        tick();
        checkOutput("rq_quiet_we", 32'(ram_we), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
